// File: rtl/axi_lite_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_lite_pkg : shared response codes, FSM states, default widths     |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package axi_lite_pkg;

    localparam int c_DEFAULT_ADDR_WIDTH = 32;
    localparam int c_DEFAULT_DATA_WIDTH = 32;
    localparam int c_DEFAULT_NUM_REGS   = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_lite_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_lite_regfile : register array, byte-strobed write, comb. read    |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int NUM_REGS   = c_DEFAULT_NUM_REGS,
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [IDX_W-1:0]        widx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [IDX_W-1:0]        ridx,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wstrb[b]) begin
                    r_mem[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = r_mem[ridx];

endmodule
`default_nettype wire

// File: rtl/axi_lite_reg_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_lite_reg_slave : AXI4-Lite slave over a bank of 32-bit registers |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
module axi_lite_reg_slave
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = c_DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int NUM_REGS   = c_DEFAULT_NUM_REGS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [2:0]              awprot,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [2:0]              arprot,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_WIDTH / 8;

    function automatic logic addr_legal(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] == 2'b00) && ((a >> (IDX_W + 2)) == '0);
    endfunction

    wr_state_t               r_wstate, w_wstate_nxt;
    rd_state_t               r_rstate, w_rstate_nxt;
    logic                    r_run;
    logic                    r_aw_held, r_w_held;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]       r_wstrb;
    logic [1:0]              r_bresp, r_rresp;
    logic [DATA_WIDTH-1:0]   r_rdata;

    logic                    w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [ADDR_WIDTH-1:0]   w_waddr;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [STRB_W-1:0]       w_wstrb;
    logic                    w_wlegal, w_rlegal;
    logic [DATA_WIDTH-1:0]   w_rf_rdata;
    logic                    w_unused;

    assign w_unused = ^{awprot, arprot};

    // Readies stay low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_run <= 1'b0;
        else      r_run <= 1'b1;
    end

    // A half already latched takes priority over the live bus value.
    assign w_waddr  = r_aw_held ? r_awaddr : awaddr;
    assign w_wdata  = r_w_held  ? r_wdata  : wdata;
    assign w_wstrb  = r_w_held  ? r_wstrb  : wstrb;
    assign w_wlegal = addr_legal(w_waddr);
    assign w_rlegal = addr_legal(araddr);
    assign w_aw_hs  = awvalid && awready;
    assign w_w_hs   = wvalid && wready;
    assign w_ar_hs  = arvalid && arready;

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_commit     = 1'b0;
        awready      = 1'b0;
        wready       = 1'b0;
        bvalid       = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                awready = r_run && !r_aw_held;
                wready  = r_run && !r_w_held;
                if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) begin
                    w_commit     = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wstate  <= W_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_wstate <= w_wstate_nxt;
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bresp   <= w_wlegal ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_awaddr  <= awaddr;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= wdata;
                    r_wstrb  <= wstrb;
                end
            end
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        arready      = 1'b0;
        rvalid       = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                arready = r_run;
                if (w_ar_hs) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Capture uses the pre-edge register value, so a same-edge write is not seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (w_ar_hs) begin
                r_rdata <= w_rlegal ? w_rf_rdata : '0;
                r_rresp <= w_rlegal ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign bresp = r_bresp;
    assign rdata = r_rdata;
    assign rresp = r_rresp;

    axi_lite_regfile #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (w_commit && w_wlegal),
        .widx  (w_waddr[2 +: IDX_W]),
        .wdata (w_wdata),
        .wstrb (w_wstrb),
        .ridx  (araddr[2 +: IDX_W]),
        .rdata (w_rf_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_reg_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axi_lite_reg_slave : directed self-checking bench for the slave   |
// | Revision              : 1.0                                          |
// +----------------------------------------------------------------------+
module tb_axi_lite_reg_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    axi_lite_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    // Called at a negedge; returns at a negedge with the B handshake done.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output int lat);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        int n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            if (awvalid && awready) aw_done = 1'b1;
            if (wvalid && wready)   w_done  = 1'b1;
            @(negedge clk); n++;
            if (aw_done) awvalid = 1'b0;
            if (w_done)  wvalid  = 1'b0;
        end
        lat = 0;
        while (!bvalid && lat < 20) begin
            @(negedge clk); lat++;
        end
        if (!bvalid) begin
            checks++;
            $display("FAIL write_timeout addr=%h: bvalid=%b required 1", a, bvalid);
        end
        resp = bresp;
        @(negedge clk);
        bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        while (!arready && n < 20) begin
            @(negedge clk); n++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge clk); n++;
        end
        if (!rvalid) begin
            checks++;
            $display("FAIL read_timeout addr=%h: rvalid=%b required 1", a, rvalid);
        end
        d = rdata; resp = rresp;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        awaddr = '0; wdata = '0; araddr = '0; wstrb = '0; awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0)
            $display("FAIL reset_handshake: got %b required 00000", {awready, wready, arready, bvalid, rvalid});
        else passes++;
        checks++;
        if ({bresp, rresp, rdata} !== 36'h0)
            $display("FAIL reset_payload: got %h required 0", {bresp, rresp, rdata});
        else passes++;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({awready, wready, arready} !== 3'b111)
            $display("FAIL post_reset_ready: got %b required 111", {awready, wready, arready});
        else passes++;
    endtask

    task automatic test_write_read;
        logic [1:0] resp; logic [31:0] d; int lat;
        axi_write(32'h04, 32'hDEADBEEF, 4'hF, resp, lat);
        checks++;
        if ({lat, resp} !== {32'd0, 2'b00})
            $display("FAIL write_latency_resp: got lat=%0d resp=%b required lat=0 resp=00", lat, resp);
        else passes++;
        axi_read(32'h04, d, resp);
        checks++;
        if ({d, resp} !== {32'hDEADBEEF, 2'b00})
            $display("FAIL read_04: got %h/%b required deadbeef/00", d, resp);
        else passes++;
    endtask

    task automatic test_strobe;
        logic [1:0] resp; logic [31:0] d; int lat;
        axi_write(32'h08, 32'hFFFFFFFF, 4'hF, resp, lat);
        axi_write(32'h08, 32'h12345678, 4'h5, resp, lat);
        checks++;
        if (resp !== 2'b00) $display("FAIL strobe_resp: got %b required 00", resp);
        else passes++;
        axi_read(32'h08, d, resp);
        checks++;
        if (d !== 32'hFF34FF78) $display("FAIL strobe_data: got %h required ff34ff78", d);
        else passes++;
        axi_write(32'h08, 32'h00000000, 4'h0, resp, lat);
        axi_read(32'h08, d, resp);
        checks++;
        if ({d, resp} !== {32'hFF34FF78, 2'b00})
            $display("FAIL zero_strobe: got %h/%b required ff34ff78/00", d, resp);
        else passes++;
    endtask

    task automatic test_w_before_aw;
        logic [1:0] resp; logic [31:0] d;
        wdata = 32'h000000A5; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bvalid, wready, awready} !== 3'b001)
                $display("FAIL w_first_wait%0d: got bvalid/wready/awready=%b required 001", i, {bvalid, wready, awready});
            else passes++;
            @(negedge clk);
        end
        awaddr = 32'h0C; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        checks++;
        if ({bvalid, bresp} !== 3'b100)
            $display("FAIL w_first_bresp: got %b required 100", {bvalid, bresp});
        else passes++;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        axi_read(32'h0C, d, resp);
        checks++;
        if (d !== 32'h000000A5) $display("FAIL w_first_data: got %h required 000000a5", d);
        else passes++;
    endtask

    task automatic test_illegal;
        logic [1:0] resp; logic [31:0] d; int lat;
        axi_write(32'h40, 32'h11111111, 4'hF, resp, lat);
        checks++;
        if (resp !== 2'b10) $display("FAIL wr_40_resp: got %b required 10", resp);
        else passes++;
        axi_write(32'h06, 32'h22222222, 4'hF, resp, lat);
        checks++;
        if (resp !== 2'b10) $display("FAIL wr_06_resp: got %b required 10", resp);
        else passes++;
        axi_read(32'h40, d, resp);
        checks++;
        if ({d, resp} !== {32'h0, 2'b10}) $display("FAIL rd_40: got %h/%b required 0/10", d, resp);
        else passes++;
        axi_read(32'h06, d, resp);
        checks++;
        if ({d, resp} !== {32'h0, 2'b10}) $display("FAIL rd_06: got %h/%b required 0/10", d, resp);
        else passes++;
        axi_read(32'h00, d, resp);
        checks++;
        if ({d, resp} !== {32'h0, 2'b00}) $display("FAIL rd_00_unchanged: got %h/%b required 0/00", d, resp);
        else passes++;
        axi_read(32'h04, d, resp);
        checks++;
        if (d !== 32'hDEADBEEF) $display("FAIL rd_04_unchanged: got %h required deadbeef", d);
        else passes++;
    endtask

    task automatic test_backpressure;
        logic [1:0] resp; logic [31:0] d;
        awaddr = 32'h10; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        awaddr = 32'h14; wdata = 32'h0BADC0DE;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bvalid, bresp, awready, wready} !== 5'b10000)
                $display("FAIL b_stall%0d: got bvalid/bresp/awready/wready=%b required 10000", i, {bvalid, bresp, awready, wready});
            else passes++;
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        checks++;
        if ({bvalid, awready, wready} !== 3'b011)
            $display("FAIL b_release: got %b required 011", {bvalid, awready, wready});
        else passes++;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        araddr = 32'h10; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        araddr = 32'h14;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rvalid, rdata, rresp, arready} !== {1'b1, 32'hCAFEF00D, 2'b00, 1'b0})
                $display("FAIL r_stall%0d: got rvalid=%b rdata=%h rresp=%b arready=%b required 1/cafef00d/00/0", i, rvalid, rdata, rresp, arready);
            else passes++;
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        @(negedge clk);
        arvalid = 1'b0;
        checks++;
        if ({rvalid, rdata} !== {1'b1, 32'h0BADC0DE})
            $display("FAIL r_after_release: got %b/%h required 1/0badc0de", rvalid, rdata);
        else passes++;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        d = '0; resp = '0;
    endtask

    task automatic test_same_cycle;
        logic [1:0] resp; logic [31:0] d;
        awaddr = 32'h1C; wdata = 32'h00000077; wstrb = 4'hF; araddr = 32'h1C;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        checks++;
        if ({rvalid, rdata, bvalid, bresp} !== {1'b1, 32'h0, 1'b1, 2'b00})
            $display("FAIL same_cycle: got rvalid=%b rdata=%h bvalid=%b bresp=%b required 1/0/1/00", rvalid, rdata, bvalid, bresp);
        else passes++;
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        axi_read(32'h1C, d, resp);
        checks++;
        if (d !== 32'h00000077) $display("FAIL same_cycle_after: got %h required 00000077", d);
        else passes++;
    endtask

    task automatic test_reset_mid;
        logic [1:0] resp; logic [31:0] d;
        wdata = 32'h00000055; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0)
            $display("FAIL mid_reset: got %b required 00000", {awready, wready, arready, bvalid, rvalid});
        else passes++;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        awaddr = 32'h18; awvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0;
        checks++;
        if ({bvalid, wready, awready} !== 3'b010)
            $display("FAIL mid_reset_aborted: got bvalid/wready/awready=%b required 010", {bvalid, wready, awready});
        else passes++;
        wdata = 32'h00000066; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        checks++;
        if ({bvalid, bresp} !== 3'b100) $display("FAIL mid_reset_bresp: got %b required 100", {bvalid, bresp});
        else passes++;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        axi_read(32'h18, d, resp);
        checks++;
        if (d !== 32'h00000066) $display("FAIL mid_reset_data: got %h required 00000066", d);
        else passes++;
        axi_read(32'h04, d, resp);
        checks++;
        if (d !== 32'h0) $display("FAIL mid_reset_cleared: got %h required 0", d);
        else passes++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_write_read;
        test_strobe;
        test_w_before_aw;
        test_illegal;
        test_backpressure;
        test_same_cycle;
        test_reset_mid;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
